// File: rtl/lpc_io_target_ctrl.sv
// LPC I/O target sequencer: decodes host I/O cycles in a 32-byte window and
// drives the register file strobe/address/data, returning read data via SYNC.
module lpc_io_target_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'h0700,
    parameter int unsigned SYNC_WAIT = 0
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       LFrame_n,
    input  logic [3:0] LadIn,
    output logic [3:0] LadOut,
    output logic       LadOe,
    output logic [7:0] Addr,
    output logic       Wr,
    output logic [7:0] DataWr,
    input  logic [7:0] DataReg,
    output logic       Busy
);

    localparam logic [3:0] WAIT_LAST = 4'(SYNC_WAIT);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CYCTYPE,
        S_ADDR0,
        S_ADDR1,
        S_ADDR2,
        S_ADDR3,
        S_WDAT0,
        S_WDAT1,
        S_HTAR0,
        S_HTAR1,
        S_SYNC,
        S_RDAT0,
        S_RDAT1,
        S_TTAR0,
        S_TTAR1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        is_write;
    logic [11:0] addr_hi;
    logic [3:0]  wdat_lo;
    logic [7:0]  rd_latch;
    logic [3:0]  wait_cnt;
    logic        hit;
    logic        ready_sync;

    // addr_hi holds address bits [15:4]; the final nibble is still on LadIn in ADDR3
    assign hit        = (addr_hi[11:1] == BASE_ADDR[15:5]);
    assign ready_sync = (state == S_SYNC) && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    state_next = S_IDLE;
            S_CYCTYPE: state_next = (LadIn[3:2] == 2'b00) ? S_ADDR0 : S_IDLE;
            S_ADDR0:   state_next = S_ADDR1;
            S_ADDR1:   state_next = S_ADDR2;
            S_ADDR2:   state_next = S_ADDR3;
            S_ADDR3: begin
                if (!hit)
                    state_next = S_IDLE;
                else
                    state_next = is_write ? S_WDAT0 : S_HTAR0;
            end
            S_WDAT0:   state_next = S_WDAT1;
            S_WDAT1:   state_next = S_HTAR0;
            S_HTAR0:   state_next = S_HTAR1;
            S_HTAR1:   state_next = S_SYNC;
            S_SYNC: begin
                if (ready_sync)
                    state_next = is_write ? S_TTAR0 : S_RDAT0;
            end
            S_RDAT0:   state_next = S_RDAT1;
            S_RDAT1:   state_next = S_TTAR0;
            S_TTAR0:   state_next = S_TTAR1;
            S_TTAR1:   state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        // A framed nibble overrides everything; the last low-frame cycle wins
        if (!LFrame_n)
            state_next = (LadIn == 4'h0) ? S_CYCTYPE : S_IDLE;
    end

    always_comb begin
        LadOe  = 1'b0;
        LadOut = 4'hF;
        case (state)
            S_SYNC: begin
                LadOe  = 1'b1;
                LadOut = ready_sync ? 4'h0 : 4'h6;
            end
            S_RDAT0: begin
                LadOe  = 1'b1;
                LadOut = rd_latch[3:0];
            end
            S_RDAT1: begin
                LadOe  = 1'b1;
                LadOut = rd_latch[7:4];
            end
            S_TTAR0: begin
                LadOe  = 1'b1;
                LadOut = 4'hF;
            end
            default: begin
                LadOe  = 1'b0;
                LadOut = 4'hF;
            end
        endcase
    end

    assign Wr   = ready_sync && is_write;
    assign Busy = (state != S_IDLE);

    always_ff @(posedge LpcClock) begin
        if (PciReset) begin
            state    <= S_IDLE;
            is_write <= 1'b0;
            addr_hi  <= '0;
            wdat_lo  <= '0;
            rd_latch <= '0;
            wait_cnt <= '0;
            Addr     <= '0;
            DataWr   <= '0;
        end else begin
            state <= state_next;
            if (LFrame_n && state == S_SYNC && !ready_sync)
                wait_cnt <= wait_cnt + 4'd1;
            else
                wait_cnt <= '0;
            if (LFrame_n) begin
                case (state)
                    S_CYCTYPE: is_write <= LadIn[1];
                    S_ADDR0:   addr_hi[11:8] <= LadIn;
                    S_ADDR1:   addr_hi[7:4]  <= LadIn;
                    S_ADDR2:   addr_hi[3:0]  <= LadIn;
                    S_ADDR3: begin
                        if (hit)
                            Addr <= {3'b000, addr_hi[0], LadIn};
                    end
                    S_WDAT0:   wdat_lo <= LadIn;
                    S_WDAT1:   DataWr  <= {LadIn, wdat_lo};
                    S_SYNC: begin
                        if (ready_sync && !is_write)
                            rd_latch <= DataReg;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lpc_io_target_ctrl.sv
// Directed bench for lpc_io_target_ctrl: one instance with no wait states and
// one with three long-wait SYNC nibbles share the same host stimulus.
module tb_lpc_io_target_ctrl;

    logic       clk;
    logic       rst;
    logic       frame_n;
    logic [3:0] lad_in;
    logic [7:0] data_reg;

    logic [3:0] lad_out0, lad_out3;
    logic       oe0, oe3;
    logic [7:0] addr0, addr3;
    logic       wr0, wr3;
    logic [7:0] dwr0, dwr3;
    logic       busy0, busy3;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt0  = 0;
    int wr_cnt3  = 0;
    int base0;
    int base3;

    lpc_io_target_ctrl #(.BASE_ADDR(16'h0700), .SYNC_WAIT(0)) dut0 (
        .LpcClock(clk), .PciReset(rst), .LFrame_n(frame_n), .LadIn(lad_in),
        .LadOut(lad_out0), .LadOe(oe0), .Addr(addr0), .Wr(wr0),
        .DataWr(dwr0), .DataReg(data_reg), .Busy(busy0)
    );

    lpc_io_target_ctrl #(.BASE_ADDR(16'h0700), .SYNC_WAIT(3)) dut3 (
        .LpcClock(clk), .PciReset(rst), .LFrame_n(frame_n), .LadIn(lad_in),
        .LadOut(lad_out3), .LadOe(oe3), .Addr(addr3), .Wr(wr3),
        .DataWr(dwr3), .DataReg(data_reg), .Busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr0 === 1'b1) wr_cnt0++;
        if (wr3 === 1'b1) wr_cnt3++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic f, input logic [3:0] n);
        frame_n = f;
        lad_in  = n;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 4'hF);
    endtask

    // START, cycle type, then the four address nibbles MSN first
    task automatic header(input logic [3:0] cyc, input logic [15:0] a);
        logic [15:0] av;
        av = a;
        drive(1'b0, 4'h0);
        drive(1'b1, cyc);
        drive(1'b1, av[15:12]);
        drive(1'b1, av[11:8]);
        drive(1'b1, av[7:4]);
        drive(1'b1, av[3:0]);
    endtask

    initial begin
        rst      = 1'b1;
        frame_n  = 1'b1;
        lad_in   = 4'hF;
        data_reg = 8'h00;
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
        check("rst_oe",   16'(oe0),      16'h0);
        check("rst_lad",  16'(lad_out0), 16'hF);
        check("rst_wr",   16'(wr0),      16'h0);
        check("rst_addr", 16'(addr0),    16'h00);
        check("rst_dwr",  16'(dwr0),     16'h00);
        check("rst_busy", 16'(busy0),    16'h0);
        rst = 1'b0;
        idle(2);

        // Write hit 0x0705 <= 0xA5
        base0 = wr_cnt0;
        drive(1'b0, 4'h0);
        check("wr_busy_cyc", 16'(busy0), 16'h1);
        drive(1'b1, 4'h2);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h7);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h5);
        check("wr_addr", 16'(addr0), 16'h05);
        drive(1'b1, 4'h5);
        drive(1'b1, 4'hA);
        check("wr_dwr_early", 16'(dwr0), 16'hA5);
        check("wr_oe_htar",   16'(oe0),  16'h0);
        check("wr_wr_htar",   16'(wr0),  16'h0);
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
        check("wr_sync_oe",  16'(oe0),      16'h1);
        check("wr_sync_lad", 16'(lad_out0), 16'h0);
        check("wr_sync_wr",  16'(wr0),      16'h1);
        check("wr_sync_dwr", 16'(dwr0),     16'hA5);
        drive(1'b1, 4'hF);
        check("wr_ttar0_oe",  16'(oe0),      16'h1);
        check("wr_ttar0_lad", 16'(lad_out0), 16'hF);
        check("wr_ttar0_wr",  16'(wr0),      16'h0);
        drive(1'b1, 4'hF);
        check("wr_ttar1_oe",   16'(oe0),   16'h0);
        check("wr_ttar1_busy", 16'(busy0), 16'h1);
        drive(1'b1, 4'hF);
        check("wr_idle_busy", 16'(busy0), 16'h0);
        check("wr_pulses", 16'(wr_cnt0 - base0), 16'd1);
        idle(6);

        // Read hit 0x071F, register holds 0x5A
        base0 = wr_cnt0;
        data_reg = 8'h5A;
        header(4'h0, 16'h071F);
        check("rd_addr", 16'(addr0), 16'h1F);
        drive(1'b1, 4'hF);
        check("rd_htar_oe", 16'(oe0), 16'h0);
        drive(1'b1, 4'hF);
        check("rd_sync_oe",  16'(oe0),      16'h1);
        check("rd_sync_lad", 16'(lad_out0), 16'h0);
        drive(1'b1, 4'hF);
        check("rd_dat0", 16'(lad_out0), 16'hA);
        drive(1'b1, 4'hF);
        check("rd_dat1", 16'(lad_out0), 16'h5);
        drive(1'b1, 4'hF);
        check("rd_ttar0_lad", 16'(lad_out0), 16'hF);
        check("rd_ttar0_oe",  16'(oe0),      16'h1);
        drive(1'b1, 4'hF);
        check("rd_ttar1_oe", 16'(oe0), 16'h0);
        drive(1'b1, 4'hF);
        check("rd_idle_busy", 16'(busy0), 16'h0);
        check("rd_no_wr", 16'(wr_cnt0 - base0), 16'd0);
        idle(6);

        // Miss: write to 0x0720, then a memory cycle type
        base0 = wr_cnt0;
        header(4'h2, 16'h0720);
        check("miss_busy", 16'(busy0), 16'h0);
        check("miss_oe",   16'(oe0),   16'h0);
        check("miss_addr_held", 16'(addr0), 16'h1F);
        drive(1'b1, 4'hA);
        drive(1'b1, 4'h5);
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
        check("miss_oe_late", 16'(oe0), 16'h0);
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h8);
        check("mem_busy", 16'(busy0), 16'h0);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h7);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h5);
        check("mem_oe", 16'(oe0), 16'h0);
        idle(4);
        check("miss_no_wr", 16'(wr_cnt0 - base0), 16'd0);
        idle(4);

        // Long-wait read on the SYNC_WAIT=3 instance, register changes during wait
        base3 = wr_cnt3;
        data_reg = 8'h11;
        header(4'h0, 16'h0704);
        check("lw_addr", 16'(addr3), 16'h04);
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
        check("lw_w0", 16'({oe3, lad_out3}), 16'h16);
        data_reg = 8'h22;
        drive(1'b1, 4'hF);
        check("lw_w1", 16'({oe3, lad_out3}), 16'h16);
        data_reg = 8'h33;
        drive(1'b1, 4'hF);
        check("lw_w2", 16'({oe3, lad_out3}), 16'h16);
        drive(1'b1, 4'hF);
        check("lw_ready", 16'({oe3, lad_out3}), 16'h10);
        data_reg = 8'hC3;
        drive(1'b1, 4'hF);
        data_reg = 8'h00;
        check("lw_dat0", 16'(lad_out3), 16'h3);
        drive(1'b1, 4'hF);
        check("lw_dat1", 16'(lad_out3), 16'hC);
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
        check("lw_ttar1_oe", 16'(oe3), 16'h0);
        check("lw_no_wr", 16'(wr_cnt3 - base3), 16'd0);
        idle(6);

        // Abort during WDAT1, then an immediate new read cycle
        base0 = wr_cnt0;
        header(4'h2, 16'h0705);
        drive(1'b1, 4'h3);
        drive(1'b0, 4'hF);
        check("ab_busy", 16'(busy0), 16'h0);
        check("ab_oe",   16'(oe0),   16'h0);
        check("ab_dwr",  16'(dwr0),  16'hA5);
        data_reg = 8'h3C;
        drive(1'b0, 4'h0);
        check("ab_restart_busy", 16'(busy0), 16'h1);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h7);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h0);
        check("ab_rd_addr", 16'(addr0), 16'h00);
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
        check("ab_rd_sync", 16'({oe0, lad_out0}), 16'h10);
        drive(1'b1, 4'hF);
        check("ab_rd_dat0", 16'(lad_out0), 16'hC);
        drive(1'b1, 4'hF);
        check("ab_rd_dat1", 16'(lad_out0), 16'h3);
        idle(3);
        check("ab_no_wr", 16'(wr_cnt0 - base0), 16'd0);
        idle(6);

        // Reset during RDAT0, then a normal read
        data_reg = 8'h5A;
        header(4'h0, 16'h071F);
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
        check("rr_dat0", 16'({oe0, lad_out0}), 16'h1A);
        rst = 1'b1;
        drive(1'b1, 4'hF);
        rst = 1'b0;
        check("rr_oe",   16'(oe0),      16'h0);
        check("rr_lad",  16'(lad_out0), 16'hF);
        check("rr_wr",   16'(wr0),      16'h0);
        check("rr_busy", 16'(busy0),    16'h0);
        check("rr_addr", 16'(addr0),    16'h00);
        idle(2);
        data_reg = 8'h81;
        header(4'h0, 16'h0702);
        check("rr2_addr", 16'(addr0), 16'h02);
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hF);
        check("rr2_sync", 16'({oe0, lad_out0}), 16'h10);
        drive(1'b1, 4'hF);
        check("rr2_dat0", 16'(lad_out0), 16'h1);
        drive(1'b1, 4'hF);
        check("rr2_dat1", 16'(lad_out0), 16'h8);
        drive(1'b1, 4'hF);
        check("rr2_ttar0", 16'({oe0, lad_out0}), 16'h1F);
        drive(1'b1, 4'hF);
        check("rr2_ttar1_oe", 16'(oe0), 16'h0);
        drive(1'b1, 4'hF);
        check("rr2_idle_busy", 16'(busy0), 16'h0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
